// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB full-speed receive control path.
package usb_rx_pkg;

    // Receive FSM states. Packet errors are split across three ERR_* states so
    // that the error flag stays visible until the next packet starts.
    typedef enum logic [3:0] {
        IDLE,
        SYNC_RCV,
        SYNC_CHK,
        DATA_RCV,
        STORE,
        EOP_WAIT,
        ERR_WAIT,
        ERR_EOP,
        ERR_IDLE
    } rx_state_t;

    // LSB-first USB SYNC pattern, as it appears in the shift register.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;
    localparam int         BYTE_BITS_DEFAULT = 8;

endpackage

// File: rtl/usb_rx_bitcnt.sv
// Decoded-bit counter. Counts bits within a byte and flags the bit that
// completes the byte. The count holds at the last position; the controller
// always leaves the counting state on that bit and clears on re-entry.
module usb_rx_bitcnt
    import usb_rx_pkg::*;
#(
    parameter int BYTE_BITS = BYTE_BITS_DEFAULT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count,
    output logic byte_done,
    output logic cnt_zero
);

    localparam int CW = $clog2(BYTE_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BYTE_BITS - 1);

    logic [CW-1:0] bit_cnt_reg;

    assign byte_done = count && (bit_cnt_reg == LAST);
    assign cnt_zero  = (bit_cnt_reg == '0);

    // Clear has priority over counting; never advance past the last bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_reg <= '0;
        end else if (clear) begin
            bit_cnt_reg <= '0;
        end else if (count && !byte_done) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive-side control FSM for the USB full-speed receiver: detects packet
// start, checks SYNC, strobes FIFO writes per data byte and flags framing
// errors. All outputs are registered and equal to a decode of the state.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         BYTE_BITS = BYTE_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);

    rx_state_t state_reg;
    rx_state_t state_next;
    logic      rcving_reg;
    logic      w_enable_reg;
    logic      r_error_reg;

    logic bit_evt;
    logic eop_bit;
    logic counting;
    logic cnt_clear;
    logic cnt_count;
    logic byte_done;
    logic cnt_zero;

    // eop wins over a plain bit when both arrive in the same bit time.
    assign bit_evt  = shift_enable && !eop;
    assign eop_bit  = shift_enable && eop;
    assign counting = (state_reg == SYNC_RCV) || (state_reg == DATA_RCV);

    // The counter restarts whenever a counting state is entered.
    assign cnt_clear = (state_next != state_reg) &&
                       ((state_next == SYNC_RCV) || (state_next == DATA_RCV));
    assign cnt_count = counting && bit_evt;

    usb_rx_bitcnt #(
        .BYTE_BITS (BYTE_BITS)
    ) u_bitcnt (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (cnt_clear),
        .count     (cnt_count),
        .byte_done (byte_done),
        .cnt_zero  (cnt_zero)
    );

    // Next-state decode; d_edge is deliberately ignored while bits are flowing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (d_edge) state_next = SYNC_RCV;
            end
            SYNC_RCV: begin
                if (eop_bit)        state_next = ERR_EOP;
                else if (byte_done) state_next = SYNC_CHK;
            end
            SYNC_CHK: begin
                state_next = (rcv_data == SYNC_BYTE) ? DATA_RCV : ERR_WAIT;
            end
            DATA_RCV: begin
                if (eop_bit)        state_next = cnt_zero ? EOP_WAIT : ERR_EOP;
                else if (byte_done) state_next = STORE;
            end
            STORE: begin
                state_next = DATA_RCV;
            end
            EOP_WAIT: begin
                if (d_edge) state_next = IDLE;
            end
            ERR_WAIT: begin
                if (eop_bit) state_next = ERR_EOP;
            end
            ERR_EOP: begin
                if (d_edge) state_next = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) state_next = SYNC_RCV;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; outputs are registered from the next state so they
    // always match the state they belong to without an input-to-output path.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            rcving_reg   <= 1'b0;
            w_enable_reg <= 1'b0;
            r_error_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rcving_reg   <= !((state_next == IDLE) || (state_next == ERR_IDLE));
            w_enable_reg <= (state_next == STORE);
            r_error_reg  <= (state_next == ERR_WAIT) || (state_next == ERR_EOP) ||
                            (state_next == ERR_IDLE);
        end
    end

    assign rcving   = rcving_reg;
    assign w_enable = w_enable_reg;
    assign r_error  = r_error_reg;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl: table of packet shapes with expected
// error/write outcomes, a write-timing scoreboard, and hand-written sequences
// for reset and simultaneous-event corner cases.
module tb_usb_rx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rcving;
    logic       w_enable;
    logic       r_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int writes_seen = 0;
    int exp_q[$];

    typedef struct {
        logic [7:0] sync;
        int         sync_bits;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        int         tail;
        int         exp_writes;
        logic       exp_err_sync;
        logic       exp_err_end;
    } pkt_t;

    pkt_t pkts[6];

    usb_rx_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every write strobe must match the next expected cycle.
    always @(negedge clk) begin
        if (w_enable === 1'b1) begin
            int e;
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got w_enable=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL write_cycle: got write at cycle %0d, expected cycle %0d", cyc, e);
                end else begin
                    $display("write at cycle %0d data %h", cyc, rcv_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending writes, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One clock slot: inputs applied at a negedge, consumed at the next posedge.
    task automatic drive(input logic de, input logic se, input logic ep);
        d_edge       = de;
        shift_enable = se;
        eop          = ep;
        @(negedge clk);
        d_edge       = 1'b0;
        shift_enable = 1'b0;
        eop          = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Eight bits with a gap slot after each; a write is due one cycle after the 8th.
    task automatic send_byte(input logic [7:0] b, input bit expect_write);
        rcv_data = b;
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && expect_write) exp_q.push_back(cyc + 1);
            drive(1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int w0;
        pkts[0] = '{8'h80, 8, 2, 8'hA5, 8'h3C, 0, 2, 1'b0, 1'b0}; // good packet
        pkts[1] = '{8'h81, 8, 2, 8'hA5, 8'h3C, 0, 0, 1'b1, 1'b1}; // bad SYNC
        pkts[2] = '{8'h80, 8, 1, 8'h5A, 8'h00, 3, 1, 1'b0, 1'b1}; // misaligned EOP
        pkts[3] = '{8'h80, 4, 0, 8'h00, 8'h00, 0, 0, 1'b0, 1'b1}; // premature EOP in SYNC
        pkts[4] = '{8'h80, 8, 2, 8'h5A, 8'hC3, 0, 2, 1'b0, 1'b0}; // good after error
        pkts[5] = '{8'h00, 8, 0, 8'h00, 8'h00, 0, 0, 1'b1, 1'b1}; // bad SYNC, no data

        // Reset state
        #12;
        check("reset_rcving", rcving, 1'b0);
        check("reset_w_enable", w_enable, 1'b0);
        check("reset_r_error", r_error, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);
        check("idle_rcving", rcving, 1'b0);

        // Packet table
        for (int r = 0; r < 6; r++) begin
            w0 = writes_seen;
            idle(2);
            drive(1'b1, 1'b0, 1'b0);
            check("start_rcving", rcving, 1'b1);
            check("start_r_error", r_error, 1'b0);
            if (pkts[r].sync_bits == 8) begin
                send_byte(pkts[r].sync, 1'b0);
                check("sync_r_error", r_error, pkts[r].exp_err_sync);
            end else begin
                rcv_data = pkts[r].sync;
                send_bits(pkts[r].sync_bits);
            end
            if (pkts[r].nbytes > 0) send_byte(pkts[r].d0, pkts[r].exp_writes != 0);
            if (pkts[r].nbytes > 1) send_byte(pkts[r].d1, pkts[r].exp_writes != 0);
            send_bits(pkts[r].tail);
            drive(1'b0, 1'b1, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
            check("pre_end_rcving", rcving, 1'b1);
            drive(1'b1, 1'b0, 1'b0);
            check("end_rcving", rcving, 1'b0);
            idle(3);
            check("end_r_error", r_error, pkts[r].exp_err_end);
            check("end_rcving_hold", rcving, 1'b0);
            checks++;
            if (writes_seen - w0 != pkts[r].exp_writes) begin
                errors++;
                $display("FAIL write_count: got %0d, expected %0d", writes_seen - w0, pkts[r].exp_writes);
            end
            check_drained("row_drained");
            $display("packet %0d: sync %h writes %0d r_error %b", r, pkts[r].sync,
                     writes_seen - w0, r_error);
        end

        // Asynchronous reset mid DATA_RCV: no partial write, stays idle after release
        idle(2);
        drive(1'b1, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_bits(3);
        check("mid_rcving", rcving, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check("async_rcving", rcving, 1'b0);
        check("async_w_enable", w_enable, 1'b0);
        check("async_r_error", r_error, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        send_bits(6);
        check("post_reset_idle", rcving, 1'b0);
        check_drained("reset_drained");
        $display("reset mid data: rcving %b r_error %b", rcving, r_error);

        // Asynchronous reset while an error is flagged
        drive(1'b1, 1'b0, 1'b0);
        send_byte(8'h81, 1'b0);
        check("err_before_reset", r_error, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check("async_err_clear", r_error, 1'b0);
        check("async_err_rcving", rcving, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);
        $display("reset in error: r_error %b", r_error);

        // Ignored d_edge in DATA_RCV and STORE, then eop together with a bit time
        drive(1'b1, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        rcv_data = 8'h77;
        send_bits(3);
        drive(1'b1, 1'b0, 1'b0);
        check("dedge_ignored_rcving", rcving, 1'b1);
        check("dedge_ignored_err", r_error, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) exp_q.push_back(cyc + 1);
            drive(1'b0, 1'b1, 1'b0);
            drive(i == 4, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("sim_eop_rcving", rcving, 1'b1);
        check("sim_eop_err", r_error, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("sim_end_rcving", rcving, 1'b0);
        check("sim_end_err", r_error, 1'b0);
        idle(2);
        check_drained("sim_drained");
        $display("simultaneous eop: rcving %b r_error %b", rcving, r_error);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
Receive-side control FSM for the USB full-speed receiver. It sequences the NRZI decode, edge-detect and shift-register datapath: it detects packet start, counts decoded bits per byte, checks the SYNC byte, and issues one-cycle FIFO write strobes per data byte. It also flags framing errors on a premature or misaligned EOP. It sits between the decode/eop-detect/shift-register datapath and the RX FIFO.

Parameters:
SYNC_BYTE, 8'h80, value the first received byte must match (LSB-first USB SYNC).
BYTE_BITS, 8, decoded bits per byte; bit counter width is clog2(BYTE_BITS)+1.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
d_edge  input  1  one-cycle pulse on any D+/D- transition, from the edge detector
eop  input  1  EOP level from the eop detector, qualified by shift_enable
shift_enable  input  1  one-cycle pulse per sampled bit time, from the timer
rcv_data  input  8  parallel byte from the RX shift register, LSB = first bit
rcving  output  1  high while a packet is in progress
w_enable  output  1  one-cycle FIFO write strobe for a good data byte
r_error  output  1  sticky packet error flag

Behaviour:
- One clock domain. The state register and bit counter reset asynchronously when n_rst=0.
- Reset state is IDLE with bit_cnt=0. Reset values of outputs: rcving=0, w_enable=0, r_error=0.
- Outputs are Moore, decoded from the registered state. There is no combinational input-to-output path.
- "bit" means shift_enable=1 && eop=0. "eop_bit" means shift_enable=1 && eop=1.
- bit_cnt increments on each bit in SYNC_RCV and DATA_RCV. It clears on entry to SYNC_RCV and on entry to DATA_RCV. "byte_done" means a bit arrives while bit_cnt==BYTE_BITS-1.
- IDLE: rcving=0, r_error holds its value. d_edge -> SYNC_RCV. This state is only reachable from reset or EOP_WAIT, so r_error=0 here.
- SYNC_RCV: rcving=1. byte_done -> SYNC_CHK. eop_bit -> ERR_EOP.
- SYNC_CHK (exactly 1 cycle): rcving=1. rcv_data==SYNC_BYTE -> DATA_RCV, otherwise -> ERR_WAIT.
- DATA_RCV: rcving=1.
  - byte_done -> STORE.
  - eop_bit with bit_cnt==0 -> EOP_WAIT (clean end).
  - eop_bit with bit_cnt!=0 -> ERR_EOP (misaligned).
- STORE (exactly 1 cycle): rcving=1, w_enable=1 -> DATA_RCV. w_enable rises on the clock edge after the 8th bit's shift_enable cycle. rcv_data is guaranteed stable through STORE.
- EOP_WAIT: rcving=1. d_edge (bus returns to idle J) -> IDLE.
- ERR_WAIT: rcving=1, r_error=1. Ignores bits. eop_bit -> ERR_EOP.
- ERR_EOP: rcving=1, r_error=1. d_edge -> ERR_IDLE.
- ERR_IDLE: rcving=0, r_error=1. d_edge -> SYNC_RCV. r_error clears on entering SYNC_RCV, so the error stays visible until the next packet starts.
- Simultaneous events:
  - A bit and eop in the same cycle is treated as eop_bit; eop has priority.
  - A d_edge in SYNC_RCV, DATA_RCV or STORE is ignored.
- n_rst asserted mid-packet returns to IDLE immediately with all outputs 0. No partial byte is written.
- The counter never wraps past BYTE_BITS-1, because byte_done always leaves the counting state.

Decomposition:
- Shared package usb_rx_pkg holds:
  - state enum rx_state_t {IDLE, SYNC_RCV, SYNC_CHK, DATA_RCV, STORE, EOP_WAIT, ERR_WAIT, ERR_EOP, ERR_IDLE};
  - localparam SYNC_BYTE_DEFAULT=8'h80 and BYTE_BITS_DEFAULT=8.
- One sub-module, usb_rx_bitcnt: a counter with clear, enable and a byte_done flag, instantiated once. The FSM stays in usb_rx_ctrl.

Test Plan:
1. Reset with n_rst=0 mid-DATA_RCV -> rcving=0, w_enable=0, r_error=0 asynchronously; the FSM stays in IDLE after release.
2. Good packet: d_edge, 8 bits with rcv_data=8'h80, then 2 bytes 8'hA5 and 8'h3C, then eop_bit at bit_cnt=0, then d_edge -> exactly 2 w_enable pulses, each 1 cycle after the 8th bit. rcving is high from the cycle after the first d_edge until the cycle after the final d_edge. r_error=0 throughout.
3. Bad SYNC: first byte 8'h81 -> r_error=1 from the cycle after SYNC_CHK, no w_enable, rcving stays 1 until eop_bit plus d_edge, then drops. r_error stays 1 until the next start d_edge.
4. Misaligned EOP: SYNC OK, 1 full byte, then 3 bits, then eop_bit -> 1 w_enable, then r_error=1. No write for the partial byte.
5. Premature EOP in SYNC: d_edge, 4 bits, eop_bit -> r_error=1, no w_enable. The next packet's d_edge clears r_error, and a subsequent good packet as in scenario 2 succeeds.
6. Simultaneous shift_enable=1 and eop=1 at bit_cnt=0 in DATA_RCV -> clean EOP, no extra w_enable. A d_edge injected during DATA_RCV is ignored and bit_cnt is unchanged.
